// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage integer ALU plus iterative RV32M/RV64M multiply/divide.
// Latency: base ops and divide special cases 1 cycle; MUL/DIV family XLEN BUSY steps + 1 FIX step.
// Backpressure: result is held in DONE until out_ready; in_ready low while busy or undrained.
// Ports: clk/rst (sync, active-high), flush (kill in-flight op), in_valid/in_ready + a/b/op request,
//        out_valid/out_ready + result/zero registered response.
module alu_muldiv #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int CW = $clog2(XLEN) + 1;

    // Base ALU codes: {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_REM    = 3'd6;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                qn_q, qn_d;         // negate product / quotient in FIX
    logic                rn_q, rn_d;         // negate remainder in FIX
    logic [XLEN-1:0]     result_q, res_d;
    logic                zero_q;
    logic                res_we;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    logic accept;
    assign accept = in_valid & in_ready & ~flush;

    // ---------------- base ALU ----------------
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] alu_res;
    assign sh = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op[3:0])
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = a - b;
            ALU_SLL:  alu_res = a << sh;
            ALU_SRL:  alu_res = a >> sh;
            ALU_SRA:  alu_res = $signed(a) >>> sh;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  alu_res = a ^ b;
            ALU_OR:   alu_res = a | b;
            ALU_AND:  alu_res = a & b;
            default:  alu_res = '0;
        endcase
    end

    // ---------------- operand preparation for mul/div ----------------
    logic [2:0]      md;
    logic            a_sgn, b_sgn, div0, ovf;
    logic [XLEN-1:0] a_mag, b_mag, early_res;
    assign md    = op[2:0];
    assign a_sgn = ((md == MD_MULH) | (md == MD_MULHSU) | (md == MD_DIV) | (md == MD_REM)) & a[XLEN-1];
    assign b_sgn = ((md == MD_MULH) | (md == MD_DIV) | (md == MD_REM)) & b[XLEN-1];
    assign a_mag = a_sgn ? -a : a;
    assign b_mag = b_sgn ? -b : b;
    assign div0  = md[2] & (b == '0);
    assign ovf   = ((md == MD_DIV) | (md == MD_REM)) & (a == MIN_NEG) & (b == '1);
    // md[1] separates remainder from quotient within the divide group
    assign early_res = div0 ? (md[1] ? a : '1) : (md[1] ? '0 : a);

    // ---------------- iteration steps ----------------
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, prod_fix;
    logic [XLEN-1:0]   quo, rem, fix_res;

    // Shift-add: low half holds remaining multiplier bits, high half the partial sum.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    // Restoring: high half is the partial remainder, low half shifts out dividend / in quotient.
    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    assign div_nxt   = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod_fix = qn_q ? -acc_q : acc_q;
    assign quo      = acc_q[XLEN-1:0];
    assign rem      = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = '0;
        case (op_q)
            MD_MUL:                fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:      fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:            fix_res = qn_q ? -quo : quo;
            default:               fix_res = rn_q ? -rem : rem;
        endcase
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        qn_d    = qn_q;
        rn_d    = rn_q;
        res_d   = result_q;
        res_we  = 1'b0;

        case (state_q)
            BUSY: begin
                acc_d = op_q[2] ? div_nxt : mul_nxt;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                res_d   = fix_res;
                res_we  = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (accept) begin
            op_d = md;
            if (!op[4]) begin
                res_d   = alu_res;
                res_we  = 1'b1;
                state_d = DONE;
            end else if (div0 | ovf) begin
                res_d   = early_res;
                res_we  = 1'b1;
                state_d = DONE;
            end else begin
                acc_d   = {{XLEN{1'b0}}, (md[2] ? a_mag : b_mag)};
                opnd_d  = md[2] ? b_mag : a_mag;
                cnt_d   = CW'(XLEN);
                qn_d    = a_sgn ^ b_sgn;
                rn_d    = a_sgn;
                state_d = BUSY;
            end
        end

        // flush kills everything in flight but leaves the visible result untouched
        if (flush) begin
            state_d = IDLE;
            res_d   = result_q;
            res_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            qn_q     <= 1'b0;
            rn_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            qn_q    <= qn_d;
            rn_q    <= rn_d;
            if (res_we) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
            end
        end
    end
endmodule
